// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side hazard signals between the pipeline and the hazard scoreboard
interface hazard_scoreboard_if #(
   parameter int CNT_W = 32,
   parameter int REG_AW = 5
);
   logic ID_insn_vld;
   logic [REG_AW-1:0] ID_rs1_addr;
   logic [REG_AW-1:0] ID_rs2_addr;
   logic ID_rs1_used;
   logic ID_rs2_used;
   logic [REG_AW-1:0] ID_rd_addr;
   logic ID_rd_wren;
   logic ID_mem_rden;
   logic EX_br_sel;
   logic [1:0] ID_forward_A;
   logic [1:0] ID_forward_B;
   logic o_stall;
   logic o_flush_IF;
   logic o_flush_ID;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [CNT_W-1:0] o_flush_cnt;
   modport master (
      output ID_insn_vld, ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
      output ID_rd_addr, ID_rd_wren, ID_mem_rden, EX_br_sel,
      input ID_forward_A, ID_forward_B, o_stall, o_flush_IF, o_flush_ID, o_stall_cnt, o_flush_cnt
   );
   modport slave (
      input ID_insn_vld, ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
      input ID_rd_addr, ID_rd_wren, ID_mem_rden, EX_br_sel,
      output ID_forward_A, ID_forward_B, o_stall, o_flush_IF, o_flush_ID, o_stall_cnt, o_flush_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB destination scoreboard driving forwarding, load-use stall and branch flush
module hazard_scoreboard #(
   parameter int CNT_W = 32,
   parameter int REG_AW = 5
) (
   input logic i_clk,
   input logic i_rst,
   hazard_scoreboard_if.slave bus
);
   typedef struct packed {
      logic vld;
      logic [REG_AW-1:0] rd;
      logic wren;
      logic load;
   } slot_t;
   slot_t ex, mem, wb;
   logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b, stall;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   function automatic logic hit(input slot_t s, input logic [REG_AW-1:0] r, input logic used);
      return s.vld & s.wren & (s.rd == r) & (|r) & used;
   endfunction
   always_comb begin
      ex_a = hit(ex, bus.ID_rs1_addr, bus.ID_rs1_used);
      ex_b = hit(ex, bus.ID_rs2_addr, bus.ID_rs2_used);
      mem_a = hit(mem, bus.ID_rs1_addr, bus.ID_rs1_used);
      mem_b = hit(mem, bus.ID_rs2_addr, bus.ID_rs2_used);
      wb_a = hit(wb, bus.ID_rs1_addr, bus.ID_rs1_used);
      wb_b = hit(wb, bus.ID_rs2_addr, bus.ID_rs2_used);
      stall = bus.ID_insn_vld & ex.load & (ex_a | ex_b) & ~bus.EX_br_sel;
      // a load in EX has no data yet, and the older MEM copy is stale, so it never forwards
      bus.ID_forward_A = (stall | (ex_a & ex.load)) ? 2'b00 : ex_a ? 2'b10 : mem_a ? 2'b01 : wb_a ? 2'b00 : 2'b00;
      bus.ID_forward_B = (stall | (ex_b & ex.load)) ? 2'b00 : ex_b ? 2'b10 : mem_b ? 2'b01 : wb_b ? 2'b00 : 2'b00;
      bus.o_stall = stall;
      bus.o_flush_IF = bus.EX_br_sel;
      bus.o_flush_ID = bus.EX_br_sel;
      bus.o_stall_cnt = stall_cnt;
      bus.o_flush_cnt = flush_cnt;
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         ex <= '0;
         mem <= '0;
         wb <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         ex <= (bus.ID_insn_vld & ~stall & ~bus.EX_br_sel) ? {1'b1, bus.ID_rd_addr, bus.ID_rd_wren, bus.ID_mem_rden} : '0;
         mem <= ex;
         wb <= mem;
         stall_cnt <= stall_cnt + CNT_W'(stall);
         flush_cnt <= flush_cnt + CNT_W'(bus.EX_br_sel);
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed plus random decode stream checked against an issue-distance reference model
module tb_hazard_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   hazard_scoreboard_if #(.CNT_W(32), .REG_AW(5)) bus ();
   hazard_scoreboard #(.CNT_W(32), .REG_AW(5)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
   typedef struct {
      int issue;
      logic [4:0] rd;
      logic w;
      logic ld;
   } ent_t;
   typedef struct {
      logic [1:0] fa;
      logic [1:0] fb;
      logic fchk;
      logic st;
      logic fl;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;
   ent_t q[$];
   exp_t exq[$];
   int t = 0;
   int n_chk = 0;
   int n_err = 0;
   logic [31:0] sc = 0, fc = 0;
   logic p_rst = 1'b0, p_stall = 1'b0, p_br = 1'b0, p_acc = 1'b0;
   logic [4:0] p_rd = 0;
   logic p_w = 1'b0, p_ld = 1'b0;
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, a, e, $time);
      end
   endtask
   // 0 none, 1 producer two issues back, 2 ALU producer one back, 3 load producer one back
   function automatic int src(input logic [4:0] r, input logic u);
      if (!u || r == 0) return 0;
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].w && q[i].rd == r) return (t - q[i].issue == 1) ? (q[i].ld ? 3 : 2) : (t - q[i].issue == 2) ? 1 : 0;
      return 0;
   endfunction
   task automatic cyc(input logic v, input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                      input logic [4:0] rd, input logic w, input logic ld, input logic br, input logic rs);
      int h1, h2;
      exp_t e;
      @(posedge clk);
      t++;
      if (!p_rst) begin
         q.delete();
         sc = 0;
         fc = 0;
      end else begin
         sc += 32'(p_stall);
         fc += 32'(p_br);
         if (p_acc) q.push_back('{t - 1, p_rd, p_w, p_ld});
      end
      while (q.size() > 0 && t - q[0].issue > 3) void'(q.pop_front());
      #1;
      rst = rs;
      bus.ID_insn_vld = v;
      bus.ID_rs1_addr = a1;
      bus.ID_rs2_addr = a2;
      bus.ID_rs1_used = u1;
      bus.ID_rs2_used = u2;
      bus.ID_rd_addr = rd;
      bus.ID_rd_wren = w;
      bus.ID_mem_rden = ld;
      bus.EX_br_sel = br;
      h1 = src(a1, u1);
      h2 = src(a2, u2);
      e.st = v && (h1 == 3 || h2 == 3) && !br;
      e.fa = e.st ? 2'b00 : h1 == 2 ? 2'b10 : h1 == 1 ? 2'b01 : 2'b00;
      e.fb = e.st ? 2'b00 : h2 == 2 ? 2'b10 : h2 == 1 ? 2'b01 : 2'b00;
      e.fchk = v && !br;
      e.fl = br;
      e.sc = sc;
      e.fc = fc;
      exq.push_back(e);
      p_rst = rs;
      p_stall = e.st;
      p_br = br;
      p_acc = v && !e.st && !br;
      p_rd = rd;
      p_w = w;
      p_ld = ld;
   endtask
   initial forever begin
      @(negedge clk);
      if (exq.size() > 0) begin
         exp_t e;
         e = exq.pop_front();
         chk("stall", 32'(bus.o_stall), 32'(e.st));
         chk("flush_IF", 32'(bus.o_flush_IF), 32'(e.fl));
         chk("flush_ID", 32'(bus.o_flush_ID), 32'(e.fl));
         chk("stall_cnt", bus.o_stall_cnt, e.sc);
         chk("flush_cnt", bus.o_flush_cnt, e.fc);
         if (e.fchk) begin
            chk("forward_A", 32'(bus.ID_forward_A), 32'(e.fa));
            chk("forward_B", 32'(bus.ID_forward_B), 32'(e.fb));
         end
      end
   end
   initial begin
      logic v, u1, u2, w, ld, br, rs;
      logic [4:0] a1, a2, rd;
      bus.ID_insn_vld = 0;
      bus.ID_rs1_addr = 0;
      bus.ID_rs2_addr = 0;
      bus.ID_rs1_used = 0;
      bus.ID_rs2_used = 0;
      bus.ID_rd_addr = 0;
      bus.ID_rd_wren = 0;
      bus.ID_mem_rden = 0;
      bus.EX_br_sel = 0;
      repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 1, 2, 1, 1, 5, 1, 0, 0, 1);
      cyc(1, 5, 7, 1, 1, 6, 1, 0, 0, 1);
      cyc(1, 1, 2, 1, 1, 5, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 1, 5, 1, 1, 8, 1, 0, 0, 1);
      cyc(1, 1, 2, 1, 1, 9, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 9, 0, 1, 0, 3, 1, 0, 0, 1);
      cyc(1, 1, 2, 1, 1, 0, 1, 0, 0, 1);
      cyc(1, 0, 0, 1, 1, 4, 1, 0, 0, 1);
      cyc(1, 1, 0, 1, 0, 5, 1, 1, 0, 1);
      cyc(1, 5, 5, 1, 1, 6, 1, 0, 0, 1);
      cyc(1, 5, 5, 1, 1, 6, 1, 0, 0, 1);
      cyc(1, 1, 0, 1, 0, 5, 1, 1, 0, 1);
      cyc(1, 5, 5, 1, 1, 6, 1, 0, 1, 1);
      cyc(1, 6, 6, 1, 1, 7, 1, 0, 0, 1);
      cyc(1, 1, 2, 1, 1, 5, 1, 0, 0, 1);
      cyc(1, 3, 4, 1, 1, 5, 1, 0, 0, 1);
      cyc(1, 5, 5, 1, 1, 6, 1, 0, 0, 1);
      cyc(1, 1, 0, 1, 0, 5, 1, 1, 0, 1);
      cyc(1, 5, 7, 1, 1, 6, 1, 0, 0, 0);
      cyc(1, 5, 7, 1, 1, 6, 1, 0, 0, 1);
      cyc(1, 5, 7, 1, 1, 6, 1, 0, 0, 1);
      {v, a1, a2, u1, u2, rd, w, ld} = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!p_stall) begin
            v = $urandom_range(0, 99) < 85;
            a1 = 5'($urandom_range(0, 7));
            a2 = 5'($urandom_range(0, 7));
            u1 = $urandom_range(0, 9) < 8;
            u2 = $urandom_range(0, 9) < 6;
            rd = 5'($urandom_range(0, 7));
            w = $urandom_range(0, 9) < 8;
            ld = $urandom_range(0, 9) < 3;
         end
         br = $urandom_range(0, 99) < 10;
         rs = $urandom_range(0, 99) >= 2;
         cyc(v, a1, a2, u1, u2, rd, w, ld, br, rs);
      end
      repeat (2) @(posedge clk);
      n_chk++;
      if (exq.size() != 0) begin
         n_err++;
         $display("FAIL drain got=%0d want=0", exq.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard controller for the 5-stage forwarding pipeline.
- Keeps a 3-slot scoreboard of in-flight destinations (EX, MEM, WB slots).
- Generates the forward-select codes consumed by the execute-stage forwarding muxes, the load-use stall, and the branch-taken flush controls.
- Sits beside the decode stage; its outputs drive the PC/IF-ID enables, ID/EX bubble insertion and the ID_forward_A/B pipeline fields.

Parameters:
CNT_W, 32, width of the stall and flush performance counters
REG_AW, 5, register address width

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  reset, synchronous, active-low
ID_insn_vld  in  1  valid instruction in decode
ID_rs1_addr  in  REG_AW  decode source 1
ID_rs2_addr  in  REG_AW  decode source 2
ID_rs1_used  in  1  instruction reads rs1
ID_rs2_used  in  1  instruction reads rs2
ID_rd_addr  in  REG_AW  decode destination
ID_rd_wren  in  1  instruction writes rd
ID_mem_rden  in  1  instruction is a load
EX_br_sel  in  1  branch/jump taken, resolved in execute
ID_forward_A  out  2  forward code for rs1: 00 regfile, 01 WB_wb_data, 10 MEM_alu_data
ID_forward_B  out  2  forward code for rs2, same encoding
o_stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
o_flush_IF  out  1  squash IF/ID register
o_flush_ID  out  1  squash ID/EX register (bubble into EX)
o_stall_cnt  out  CNT_W  load-use stall cycles since reset
o_flush_cnt  out  CNT_W  taken-branch flushes since reset

Behaviour:
- Slot format: {vld, rd, wren, load}. Each cycle slots shift ID->EX->MEM->WB; the WB slot retires.
- The ID entry is written into the EX slot only when ID_insn_vld=1, o_stall=0 and EX_br_sel=0. Otherwise the EX slot receives a bubble (vld=0).
- A slot "hits" source r when: vld & wren & rd==r & r!=0 & the corresponding rs*_used.
- Forward code is combinational, priority youngest first:
  - EX-slot hit (non-load) -> 10, because the producer sits in MEM when the consumer reaches EX.
  - else MEM-slot hit -> 01, because the producer sits in WB.
  - else 00. A WB-slot hit also gives 00, since the register file is write-through (same-cycle read sees the write).
- Load-use: an EX-slot hit with load=1 asserts o_stall=1 for exactly one cycle.
  - The stalled instruction re-evaluates next cycle; the load is then in the MEM slot, so the code becomes 01.
  - Forward codes during the stall cycle are don't-care but driven to 00.
- Both sources hitting the same load produce one stall, not two.
- Branch: EX_br_sel=1 -> o_flush_IF=1 and o_flush_ID=1 in the same cycle (combinational).
  - The ID entry is discarded; the EX slot receives a bubble.
  - EX_br_sel overrides a simultaneous load-use condition: o_stall forced to 0 and o_stall_cnt not incremented.
- Back-to-back producers to the same rd: the youngest wins (EX slot over MEM slot).
- Counters:
  - o_stall_cnt increments on each cycle with o_stall=1.
  - o_flush_cnt increments on each cycle with EX_br_sel=1.
  - Both wrap modulo 2^CNT_W with no saturation.
- Reset (i_rst=0 at a rising edge):
  - All slots vld=0 and both counters 0.
  - Outputs, being combinational, then read ID_forward_A/B=00, o_stall=0, o_flush_IF=o_flush_ID=0, provided EX_br_sel=0.
- Reset asserted mid-stall clears the slots, so the stall drops on the cycle after reset.
- ID_insn_vld=0 never causes a stall and never allocates a slot.
- Latency: hazard detection 0 cycles (combinational on ID inputs plus registered slots); slot state updated 1 cycle later.

Test Plan:
- ALU dependency: add x5 followed by sub x6,x5,x7 -> ID_forward_A=10 on the sub decode cycle, o_stall=0.
- Distance 2: add x5, nop, or x8,x1,x5 -> ID_forward_B=01; distance 3 -> 00; writes or uses of x0 -> always 00.
- Load-use: lw x5 then add x6,x5,x5 -> o_stall=1 for one cycle; next cycle both codes=01, o_stall_cnt=1.
- Branch over hazard: EX_br_sel=1 in the same cycle as a load-use hit -> o_stall=0, o_flush_IF=o_flush_ID=1, o_flush_cnt=1, o_stall_cnt unchanged; the following decode sees no hit from the discarded instruction.
- Youngest wins: add x5, add x5, sub uses x5 -> code 10, not 01.
- Reset: pull i_rst low during a stall, release -> all outputs 0, counters 0, and a previously-hit rd no longer forwards.
